// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer controller.
// Allocates entries in program order from a tail pointer and drives a one-hot
// select into the entry array. Broadcasts the head (commit) pointer and
// advances it when the head entry pulses its write-enable. Tracks occupancy
// and supports drain (stop allocating until empty) and flush.
//
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   alloc_req     decode requests an entry
//   alloc_gnt     allocation accepted this cycle (combinational)
//   alloc_idx     granted entry index (current tail)
//   sel           one-hot entry select, zero when no grant
//   entry_wen     per-entry commit write-enable pulses
//   head          commit pointer
//   commit_valid  registered pulse: one entry retired
//   commit_idx    index of retired entry, valid with commit_valid
//   count         occupied entries, 0..DEPTH
//   full, empty   decoded from registered count
//   drain_req     stop allocating until empty
//   drain_done    high while halted after a drain
//   flush         discard all entries
//   order_err     sticky: write-enable seen at a non-head entry or while empty
module rob_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [PTR_W-1:0] alloc_idx,
    output logic [DEPTH-1:0] sel,
    input  logic [DEPTH-1:0] entry_wen,
    output logic [PTR_W-1:0] head,
    output logic             commit_valid,
    output logic [PTR_W-1:0] commit_idx,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    input  logic             drain_req,
    output logic             drain_done,
    input  logic             flush,
    output logic             order_err
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] tail;
    logic             commit;
    logic             wen_bad;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign alloc_idx = tail;

    assign commit  = entry_wen[head] & ~empty;
    // Any enable away from head is out of order; any enable at all while
    // empty has no entry to retire.
    assign wen_bad = ((entry_wen & ~(DEPTH'(1) << head)) != '0) ||
                     ((entry_wen != '0) && empty);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n || flush) state <= RUN;
        else                 state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (drain_req) state_nxt = DRAIN;
            // No grants in DRAIN, so a lone entry committing now empties us.
            DRAIN:   if (empty || (count == CNT_ONE && commit)) state_nxt = HALT;
            HALT:    if (!drain_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        alloc_gnt  = 1'b0;
        drain_done = 1'b0;
        case (state)
            RUN:     alloc_gnt  = alloc_req & ~full & ~flush & rst_n;
            HALT:    drain_done = 1'b1;
            default: ;
        endcase
        sel = alloc_gnt ? (DEPTH'(1) << tail) : '0;
    end

    // Pointers, occupancy, commit pulse and error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_idx   <= '0;
            order_err    <= 1'b0;
        end else begin
            if (wen_bad) order_err <= 1'b1;
            if (flush) begin
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                commit_valid <= 1'b0;
            end else begin
                commit_valid <= commit;
                if (commit) begin
                    commit_idx <= head;
                    head       <= head + PTR_ONE;
                end
                if (alloc_gnt) tail <= tail + PTR_ONE;
                if (alloc_gnt && !commit)      count <= count + CNT_ONE;
                else if (!alloc_gnt && commit) count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: directed scenarios plus random stimulus,
// compared against a queue-based reference model of the buffer.
module tb_rob_ctrl;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_gnt;
    logic [2:0] alloc_idx;
    logic [7:0] sel;
    logic [7:0] entry_wen = '0;
    logic [2:0] head;
    logic       commit_valid;
    logic [2:0] commit_idx;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       drain_req = 1'b0;
    logic       drain_done;
    logic       flush = 1'b0;
    logic       order_err;

    rob_ctrl #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
        .alloc_idx(alloc_idx), .sel(sel), .entry_wen(entry_wen), .head(head),
        .commit_valid(commit_valid), .commit_idx(commit_idx), .count(count),
        .full(full), .empty(empty), .drain_req(drain_req), .drain_done(drain_done),
        .flush(flush), .order_err(order_err)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of outstanding entry indices in program order.
    int unsigned m_q[$];
    int unsigned m_head = 0, m_tail = 0;
    int unsigned m_cidx = 0;
    bit          m_cv = 0, m_err = 0, m_known = 0;
    bit          m_draining = 0, m_halted = 0;

    function automatic logic [7:0] wen_head();
        logic [7:0] w;
        w = '0;
        w[m_head] = 1'b1;
        return w;
    endfunction

    task automatic step(input logic r_n, input logic req, input logic [7:0] wen,
                        input logic drn, input logic fl);
        bit gnt, cmt, bad;
        int unsigned exp_sel;
        rst_n = r_n; alloc_req = req; entry_wen = wen; drain_req = drn; flush = fl;
        #1;
        gnt = r_n && !m_draining && !m_halted && req && (m_q.size() < D) && !fl;
        exp_sel = gnt ? (1 << m_tail) : 0;
        if (m_known) begin
            check("alloc_gnt", alloc_gnt, gnt);
            check("sel", sel, exp_sel);
            check("alloc_idx", alloc_idx, m_tail);
        end
        cmt = wen[m_head] && (m_q.size() > 0);
        bad = ((wen & ~(8'(1) << m_head)) != 0) || (wen != 0 && m_q.size() == 0);
        @(posedge clk);
        if (!r_n || fl) begin
            m_q.delete();
            m_head = 0; m_tail = 0; m_cv = 0;
            m_draining = 0; m_halted = 0;
            if (!r_n) begin m_cidx = 0; m_err = 0; end
            else m_err = m_err | bad;
            m_known = 1;
        end else begin
            m_err = m_err | bad;
            m_cv = cmt;
            if (cmt) begin
                m_cidx = m_q.pop_front();
                m_head = (m_head + 1) % D;
            end
            if (gnt) begin
                m_q.push_back(m_tail);
                m_tail = (m_tail + 1) % D;
            end
            if (m_halted) begin
                if (!drn) m_halted = 0;
            end else if (m_draining) begin
                if (m_q.size() == 0) begin m_draining = 0; m_halted = 1; end
            end else if (drn) m_draining = 1;
        end
        #1;
        if (m_known) begin
            check("head", head, m_head);
            check("count", count, m_q.size());
            check("full", full, m_q.size() == D);
            check("empty", empty, m_q.size() == 0);
            check("commit_valid", commit_valid, m_cv);
            if (m_cv) check("commit_idx", commit_idx, m_cidx);
            if (!r_n) check("commit_idx_rst", commit_idx, 0);
            check("drain_done", drain_done, m_halted);
            check("order_err", order_err, m_err);
        end
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
    endtask

    task automatic allocs(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0);
    endtask

    task automatic commits(input int n);
        for (int i = 0; i < n; i++) step(1, 0, wen_head(), 0, 0);
    endtask

    initial begin
        logic       drn_r;
        logic [7:0] w;
        int unsigned r;

        // Fill to full, then one refused request.
        do_reset();
        allocs(9);

        // Three allocations, three in-order commits.
        do_reset();
        allocs(3);
        step(1, 0, 8'h01, 0, 0);
        step(1, 0, 8'h02, 0, 0);
        step(1, 0, 8'h04, 0, 0);
        step(1, 0, 8'h00, 0, 0);

        // Full with head=5: commit does not free a slot until next cycle.
        do_reset();
        allocs(8);
        commits(5);
        allocs(5);
        step(1, 1, 8'h20, 0, 0);
        step(1, 1, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);

        // Pointer wrap from 6.
        do_reset();
        allocs(6);
        commits(6);
        allocs(4);
        commits(4);

        // Drain with two outstanding entries.
        do_reset();
        allocs(2);
        step(1, 0, 0, 1, 0);
        step(1, 1, wen_head(), 1, 0);
        step(1, 1, wen_head(), 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);

        // Out-of-order enable, then flush keeps the sticky error.
        do_reset();
        step(1, 0, 8'h04, 0, 0);
        allocs(5);
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        // Reset mid-operation clears everything, including order_err.
        allocs(3);
        step(0, 1, 8'h01, 0, 0);
        step(1, 0, 0, 0, 0);

        // Random traffic.
        drn_r = 0;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      w = wen_head();
            else if (r < 49) w = 8'($urandom);
            else             w = '0;
            if ($urandom_range(0, 19) == 0) drn_r = ~drn_r;
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 6),
                 w, drn_r,
                 ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
